// File: rtl/sonar_pkg.sv
// Shared types and helpers for the sonar sweep engine.
// State codes, sweep direction constants and counter sizing.
package sonar_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    POSICIONA   = 4'd1,
    DISPARA     = 4'd2,
    ESPERA_ECHO = 4'd3,
    MEDE        = 4'd4,
    ENVIA       = 4'd5,
    PROXIMA     = 4'd6
  } estado_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Bits needed to count 0..max-1 for the largest of four cycle counts.
  function automatic int cnt_width(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sonar_medidor_echo.sv
// Echo edge detection, cm counting with saturation and timeout.
// Define SONAR_ECHO_SYNC_EN to add a 2-flop echo synchroniser.
import sonar_pkg::*;

module sonar_medidor_echo #(
  parameter int DIST_W         = 12,
  parameter int CYCLES_PER_CM  = 2941,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int MAX_CM         = 400
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              echo,
  output logic              subida,
  output logic              fim,
  output logic              timeout,
  output logic [DIST_W-1:0] medida
);

  localparam int TW = cnt_width(TIMEOUT_CYCLES, 1, 1, 1);
  localparam int SW = cnt_width(CYCLES_PER_CM, 1, 1, 1);

  typedef enum logic [1:0] {
    M_LIVRE,
    M_ESPERA,
    M_MEDE
  } fase_t;

  fase_t             fase_q, fase_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     sub_q, sub_d;
  logic [DIST_W-1:0] cm_q, cm_d;
  logic              e, e_q;
  logic              rise;
  logic              conta;

`ifdef SONAR_ECHO_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clock) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], echo};
  end

  assign e = sync_q[1];
`else
  assign e = echo;
`endif

  assign rise   = e & ~e_q;
  assign medida = cm_q;

  always_comb begin
    fase_d  = fase_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    cm_d    = cm_q;
    subida  = 1'b0;
    fim     = 1'b0;
    timeout = 1'b0;
    conta   = 1'b0;
    unique case (fase_q)
      M_LIVRE: begin
        if (start) begin
          fase_d = M_ESPERA;
          cnt_d  = '0;
          sub_d  = '0;
          cm_d   = '0;
        end
      end
      M_ESPERA: begin
        if (rise) begin
          subida = 1'b1;
          fase_d = M_MEDE;
          cnt_d  = '0;
          conta  = 1'b1;
        end else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          fim     = 1'b1;
          timeout = 1'b1;
          fase_d  = M_LIVRE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      M_MEDE: begin
        if (!e) begin
          fim    = 1'b1;
          fase_d = M_LIVRE;
        end else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          fim     = 1'b1;
          timeout = 1'b1;
          fase_d  = M_LIVRE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          conta = 1'b1;
        end
      end
      default: fase_d = M_LIVRE;
    endcase
    // The rise cycle counts as the first echo-high cycle.
    if (conta) begin
      if (sub_q == SW'(CYCLES_PER_CM - 1)) begin
        sub_d = '0;
        if (cm_q != DIST_W'(MAX_CM)) cm_d = cm_q + 1'b1;
      end else begin
        sub_d = sub_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fase_q <= M_LIVRE;
      cnt_q  <= '0;
      sub_q  <= '0;
      cm_q   <= '0;
      e_q    <= 1'b0;
    end else begin
      fase_q <= fase_d;
      cnt_q  <= cnt_d;
      sub_q  <= sub_d;
      cm_q   <= cm_d;
      e_q    <= e;
    end
  end

endmodule

// File: rtl/sonar_varredura.sv
// Sonar sweep engine: servo stepping, trigger, result handshake.
// Optional echo synchroniser via SONAR_ECHO_SYNC_EN (in the medidor).
import sonar_pkg::*;

module sonar_varredura #(
  parameter int N_POS          = 8,
  parameter int POS_W          = 3,
  parameter int DIST_W         = 12,
  parameter int CYCLES_PER_CM  = 2941,
  parameter int TRIGGER_CYCLES = 500,
  parameter int SETTLE_CYCLES  = 25000000,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int MAX_CM         = 400
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ligar,
  input  logic              modo,
  input  logic              echo,
  output logic              trigger,
  output logic [POS_W-1:0]  posicao,
  output logic [DIST_W-1:0] medida,
  output logic [POS_W-1:0]  medida_pos,
  output logic              medida_timeout,
  output logic              medida_valid,
  input  logic              medida_ready,
  output logic              fim_posicao,
  output logic [3:0]        db_estado
);

  localparam int CW = cnt_width(SETTLE_CYCLES, TRIGGER_CYCLES,
                                TIMEOUT_CYCLES, CYCLES_PER_CM);

  localparam logic [POS_W-1:0] P_ULT = POS_W'(N_POS - 1);
  localparam logic [POS_W-1:0] P_PEN = POS_W'(N_POS - 2);

  estado_t           estado_q, estado_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [POS_W-1:0]  posicao_q, posicao_d;
  logic              dir_q, dir_d;
  logic              trigger_q, trigger_d;
  logic              valid_q, valid_d;
  logic [DIST_W-1:0] medida_q, medida_d;
  logic [POS_W-1:0]  mpos_q, mpos_d;
  logic              mtmo_q, mtmo_d;
  logic              fimpos_q, fimpos_d;

  logic              start;
  logic              subida;
  logic              fim;
  logic              tmo;
  logic [DIST_W-1:0] cm;

  sonar_medidor_echo #(
    .DIST_W         (DIST_W),
    .CYCLES_PER_CM  (CYCLES_PER_CM),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .MAX_CM         (MAX_CM)
  ) u_medidor (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .echo    (echo),
    .subida  (subida),
    .fim     (fim),
    .timeout (tmo),
    .medida  (cm)
  );

  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    posicao_d = posicao_q;
    dir_d     = dir_q;
    trigger_d = trigger_q;
    valid_d   = valid_q;
    medida_d  = medida_q;
    mpos_d    = mpos_q;
    mtmo_d    = mtmo_q;
    fimpos_d  = 1'b0;
    start     = 1'b0;
    unique case (estado_q)
      INICIAL: begin
        if (ligar) begin
          estado_d = POSICIONA;
          cnt_d    = '0;
        end
      end
      POSICIONA: begin
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          estado_d  = DISPARA;
          cnt_d     = '0;
          trigger_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DISPARA: begin
        if (cnt_q == CW'(TRIGGER_CYCLES - 1)) begin
          estado_d  = ESPERA_ECHO;
          cnt_d     = '0;
          trigger_d = 1'b0;
          start     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ESPERA_ECHO, MEDE: begin
        if (fim) begin
          estado_d = ENVIA;
          valid_d  = 1'b1;
          medida_d = tmo ? DIST_W'(MAX_CM) : cm;
          mtmo_d   = tmo;
          mpos_d   = posicao_q;
        end else if (subida) begin
          estado_d = MEDE;
        end
      end
      ENVIA: begin
        if (medida_ready) begin
          estado_d = PROXIMA;
          valid_d  = 1'b0;
          fimpos_d = (posicao_q == P_ULT) ||
                     (posicao_q == '0 && dir_q == DIR_DOWN);
        end
      end
      PROXIMA: begin
        estado_d = ligar ? POSICIONA : INICIAL;
        cnt_d    = '0;
        if (!modo) begin
          dir_d     = DIR_UP;
          posicao_d = (posicao_q == P_ULT) ? '0 : posicao_q + 1'b1;
        end else if (dir_q == DIR_UP) begin
          // Turn around without repeating the end index.
          if (posicao_q == P_ULT) begin
            dir_d     = DIR_DOWN;
            posicao_d = P_PEN;
          end else begin
            posicao_d = posicao_q + 1'b1;
          end
        end else begin
          if (posicao_q == '0) begin
            dir_d     = DIR_UP;
            posicao_d = POS_W'(1);
          end else begin
            posicao_d = posicao_q - 1'b1;
          end
        end
      end
      default: estado_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q  <= INICIAL;
      cnt_q     <= '0;
      posicao_q <= '0;
      dir_q     <= DIR_UP;
      trigger_q <= 1'b0;
      valid_q   <= 1'b0;
      medida_q  <= '0;
      mpos_q    <= '0;
      mtmo_q    <= 1'b0;
      fimpos_q  <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      posicao_q <= posicao_d;
      dir_q     <= dir_d;
      trigger_q <= trigger_d;
      valid_q   <= valid_d;
      medida_q  <= medida_d;
      mpos_q    <= mpos_d;
      mtmo_q    <= mtmo_d;
      fimpos_q  <= fimpos_d;
    end
  end

  assign trigger        = trigger_q;
  assign posicao        = posicao_q;
  assign medida         = medida_q;
  assign medida_pos     = mpos_q;
  assign medida_timeout = mtmo_q;
  assign medida_valid   = valid_q;
  assign fim_posicao    = fimpos_q;
  assign db_estado      = estado_q;

endmodule

// File: tb/tb_sonar_varredura.sv
// Directed bench for sonar_varredura with a small configuration.
// N_POS=4, CYCLES_PER_CM=10, TRIGGER=5, SETTLE=20, TIMEOUT=500, MAX=40.
module tb_sonar_varredura;

  logic        clock;
  logic        reset;
  logic        ligar;
  logic        modo;
  logic        echo;
  logic        trigger;
  logic [1:0]  posicao;
  logic [11:0] medida;
  logic [1:0]  medida_pos;
  logic        medida_timeout;
  logic        medida_valid;
  logic        medida_ready;
  logic        fim_posicao;
  logic [3:0]  db_estado;

  int n_checks = 0;
  int n_errors = 0;
  int fim_cnt  = 0;

  sonar_varredura #(
    .N_POS          (4),
    .POS_W          (2),
    .DIST_W         (12),
    .CYCLES_PER_CM  (10),
    .TRIGGER_CYCLES (5),
    .SETTLE_CYCLES  (20),
    .TIMEOUT_CYCLES (500),
    .MAX_CM         (40)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ligar          (ligar),
    .modo           (modo),
    .echo           (echo),
    .trigger        (trigger),
    .posicao        (posicao),
    .medida         (medida),
    .medida_pos     (medida_pos),
    .medida_timeout (medida_timeout),
    .medida_valid   (medida_valid),
    .medida_ready   (medida_ready),
    .fim_posicao    (fim_posicao),
    .db_estado      (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock)
    if (fim_posicao === 1'b1) fim_cnt++;

  task automatic check_eq(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  // One measurement: wait trigger, echo after atraso for largura
  // cycles, drop ligar at echo cycle queda, then wait for valid.
  task automatic medir(
    input  int atraso,
    input  int largura,
    input  int queda,
    output int trig_w
  );
    int n;
    n = 0;
    while (trigger !== 1'b1 && n < 3000) begin
      tick(1);
      n++;
    end
    check_eq("wait_trigger", 32'(n < 3000), 1);
    trig_w = 0;
    while (trigger === 1'b1 && trig_w < 100) begin
      tick(1);
      trig_w++;
    end
    tick(atraso);
    for (int i = 0; i < largura; i++) begin
      if (i == queda) ligar = 1'b0;
      echo = 1'b1;
      tick(1);
    end
    echo = 1'b0;
    n = 0;
    while (medida_valid !== 1'b1 && n < 3000) begin
      tick(1);
      n++;
    end
    check_eq("wait_valid", 32'(n < 3000), 1);
  endtask

  int tw;
  int base;
  int trig_seen;
  int unstable;
  logic [11:0] med_hold;
  logic [1:0] exp_wrap [5];
  logic [1:0] exp_pp [8];

  initial begin
    exp_wrap = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_pp   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1};
    reset        = 1'b1;
    ligar        = 1'b0;
    modo         = 1'b0;
    echo         = 1'b0;
    medida_ready = 1'b0;
    tick(3);
    check_eq("rst_estado", db_estado, 0);
    check_eq("rst_trigger", trigger, 0);
    check_eq("rst_valid", medida_valid, 0);
    check_eq("rst_posicao", posicao, 0);
    check_eq("rst_medida", medida, 0);
    check_eq("rst_fim", fim_posicao, 0);
    reset = 1'b0;

    // Basic measurement with backpressure.
    ligar = 1'b1;
    medir(30, 255, -1, tw);
    check_eq("basic_trig_w", tw, 5);
    check_eq("basic_medida", medida, 25);
    check_eq("basic_pos", medida_pos, 0);
    check_eq("basic_tmo", medida_timeout, 0);
    check_eq("basic_estado", db_estado, 5);
    med_hold  = medida;
    trig_seen = 0;
    unstable  = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (trigger === 1'b1) trig_seen++;
      if (medida_valid !== 1'b1 || medida !== med_hold) unstable++;
    end
    check_eq("hold_stable", unstable, 0);
    check_eq("hold_no_trig", trig_seen, 0);
    medida_ready = 1'b1;
    tick(1);
    check_eq("hs_valid_drop", medida_valid, 0);
    check_eq("hs_proxima", db_estado, 6);
    tick(1);
    check_eq("hs_posicao", posicao, 1);
    check_eq("hs_posiciona", db_estado, 1);

    // Wrap sweep.
    do_reset;
    modo = 1'b0;
    ligar = 1'b1;
    medida_ready = 1'b1;
    base = fim_cnt;
    for (int k = 0; k < 5; k++) begin
      medir(10, 100, -1, tw);
      check_eq($sformatf("wrap_pos%0d", k), medida_pos, exp_wrap[k]);
      check_eq($sformatf("wrap_med%0d", k), medida, 10);
    end
    check_eq("wrap_fim", fim_cnt - base, 1);

    // Ping-pong sweep.
    do_reset;
    modo = 1'b1;
    base = fim_cnt;
    for (int k = 0; k < 8; k++) begin
      medir(10, 100, -1, tw);
      check_eq($sformatf("pp_pos%0d", k), medida_pos, exp_pp[k]);
    end
    check_eq("pp_fim", fim_cnt - base, 2);

    // Timeouts and saturation.
    do_reset;
    modo = 1'b0;
    medida_ready = 1'b0;
    medir(0, 0, -1, tw);
    check_eq("tmo_rise_med", medida, 40);
    check_eq("tmo_rise_flag", medida_timeout, 1);
    medida_ready = 1'b1;
    tick(1);
    medida_ready = 1'b0;
    medir(10, 1000, -1, tw);
    check_eq("tmo_fall_med", medida, 40);
    check_eq("tmo_fall_flag", medida_timeout, 1);
    check_eq("tmo_fall_pos", medida_pos, 1);
    medida_ready = 1'b1;
    tick(1);
    medida_ready = 1'b0;
    medir(10, 450, -1, tw);
    check_eq("sat_med", medida, 40);
    check_eq("sat_flag", medida_timeout, 0);
    medida_ready = 1'b1;
    tick(1);

    // ligar dropped mid-measurement.
    do_reset;
    ligar = 1'b1;
    medida_ready = 1'b1;
    medir(5, 100, 20, tw);
    check_eq("drop_med", medida, 10);
    tick(3);
    check_eq("drop_estado", db_estado, 0);
    check_eq("drop_pos", posicao, 1);
    trig_seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (trigger === 1'b1) trig_seen++;
    end
    check_eq("drop_idle_trig", trig_seen, 0);
    check_eq("drop_pos_hold", posicao, 1);

    // Resume, then reset while in ENVIA.
    ligar = 1'b1;
    medida_ready = 1'b0;
    medir(5, 50, -1, tw);
    check_eq("resume_pos", medida_pos, 1);
    check_eq("resume_med", medida, 5);
    reset = 1'b1;
    tick(1);
    check_eq("rst_envia_valid", medida_valid, 0);
    check_eq("rst_envia_pos", posicao, 0);
    check_eq("rst_envia_estado", db_estado, 0);
    reset = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
